// File: rtl/hiscore_ram_arb.sv
// Arbitrates the game RAM between the CPU and the hiscore engine: pause the CPU, wait for a safe
// bus boundary (or time out), let the mux settle, then hand the RAM to the hiscore side.
module hiscore_ram_arb #(
    parameter int unsigned AW            = 10,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SAFE_TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          hs_access,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_write,
    output logic [7:0]    hs_rdata,
    output logic          hs_granted,

    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_write,
    input  logic          cpu_cycle_end,
    output logic          cpu_pause,

    output logic [AW-1:0] ram_address,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_q
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSafe,
        StSettle,
        StOwned,
        StRelease
    } state_e;

    localparam logic [7:0] TimeoutVal = 8'(SAFE_TIMEOUT);
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  hs_rdata_q, hs_rdata_d;
    logic        hs_side;

    // Mux already points at the hiscore side while settling and releasing, but writes stay off.
    assign hs_side = (state_q == StSettle) || (state_q == StOwned) || (state_q == StRelease);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            StIdle: begin
                if (hs_access) begin
                    state_d    = StWaitSafe;
                    wait_cnt_d = 8'd0;
                end
            end
            StWaitSafe: begin
                // Losing the request wins over any safe point or timeout.
                if (!hs_access) begin
                    state_d = StIdle;
                end else if (cpu_cycle_end || (wait_cnt_q == TimeoutVal)) begin
                    state_d      = StSettle;
                    settle_cnt_d = SettleLoad;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StSettle: begin
                if (!hs_access) begin
                    state_d = StRelease;
                end else if (settle_cnt_q == 4'd0) begin
                    state_d = StOwned;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            StOwned: begin
                if (!hs_access) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ram_address = hs_side ? hs_address : cpu_address;
        ram_wdata   = hs_side ? hs_wdata : cpu_wdata;
        ram_we      = 1'b0;

        case (state_q)
            StIdle, StWaitSafe: ram_we = cpu_write;
            // A dropping request blocks the write in its final owned cycle.
            StOwned:            ram_we = hs_write & hs_access;
            default:            ram_we = 1'b0;
        endcase

        hs_rdata_d = hs_side ? ram_q : hs_rdata_q;
    end

    assign cpu_pause  = (state_q != StIdle);
    assign hs_granted = (state_q == StOwned);
    assign hs_rdata   = hs_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wait_cnt_q   <= 8'd0;
            settle_cnt_q <= 4'd0;
            hs_rdata_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            hs_rdata_q   <= hs_rdata_d;
        end
    end

endmodule

// File: tb/tb_hiscore_ram_arb.sv
// Self-checking bench for hiscore_ram_arb: IDLE mux vectors, handover timing, timeout, abort and
// reset-during-ownership sequences, with a write scoreboard fed from the stimulus.
module tb_hiscore_ram_arb;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hs_access;
    logic [AW-1:0] hs_address;
    logic [7:0]    hs_wdata;
    logic          hs_write;
    logic [7:0]    hs_rdata;
    logic          hs_granted;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_wdata;
    logic          cpu_write;
    logic          cpu_cycle_end;
    logic          cpu_pause;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    bit   [7:0]    ram_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hiscore_ram_arb #(
        .AW            (AW),
        .SETTLE_CYCLES (2),
        .SAFE_TIMEOUT  (255)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hs_access     (hs_access),
        .hs_address    (hs_address),
        .hs_wdata      (hs_wdata),
        .hs_write      (hs_write),
        .hs_rdata      (hs_rdata),
        .hs_granted    (hs_granted),
        .cpu_address   (cpu_address),
        .cpu_wdata     (cpu_wdata),
        .cpu_write     (cpu_write),
        .cpu_cycle_end (cpu_cycle_end),
        .cpu_pause     (cpu_pause),
        .ram_address   (ram_address),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_q         (ram_q)
    );

    // Synchronous game RAM model with a few preset locations.
    bit [7:0] mem [1024];
    bit       wr_seen [1024];

    function automatic logic [7:0] rd(input logic [AW-1:0] a);
        if (wr_seen[a]) return mem[a];
        case (a)
            10'h010: return 8'h5C;
            10'h020: return 8'h99;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_we === 1'b1) begin
            mem[ram_address]     <= ram_wdata;
            wr_seen[ram_address] <= 1'b1;
        end
        ram_q <= rd(ram_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Write scoreboard: expected writes pushed with stimulus, popped when ram_we is seen.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t wq[$];
    wr_t exp_w;

    task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h want no write",
                         ram_address, ram_wdata);
            end else begin
                exp_w = wq.pop_front();
                check("write_addr", 32'(ram_address), 32'(exp_w.a));
                check("write_data", 32'(ram_wdata), 32'(exp_w.d));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    typedef struct packed {
        logic [AW-1:0] ca;
        logic [7:0]    cd;
        logic          cw;
        logic [AW-1:0] ha;
        logic [7:0]    hd;
        logic          hw;
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        logic          ewe;
    } vec_t;

    vec_t vt [4];
    int   n;

    initial begin
        vt[0] = '{ca: 10'h040, cd: 8'h12, cw: 1'b0, ha: 10'h3FF, hd: 8'hEE, hw: 1'b1,
                  ea: 10'h040, ed: 8'h12, ewe: 1'b0};
        vt[1] = '{ca: 10'h300, cd: 8'h34, cw: 1'b1, ha: 10'h155, hd: 8'h00, hw: 1'b0,
                  ea: 10'h300, ed: 8'h34, ewe: 1'b1};
        vt[2] = '{ca: 10'h301, cd: 8'hC3, cw: 1'b1, ha: 10'h123, hd: 8'hA5, hw: 1'b1,
                  ea: 10'h301, ed: 8'hC3, ewe: 1'b1};
        vt[3] = '{ca: 10'h2AA, cd: 8'h5A, cw: 1'b0, ha: 10'h010, hd: 8'hFF, hw: 1'b1,
                  ea: 10'h2AA, ed: 8'h5A, ewe: 1'b0};

        reset_n = 1'b0; hs_access = 1'b0; hs_address = '0; hs_wdata = '0; hs_write = 1'b0;
        cpu_address = '0; cpu_wdata = '0; cpu_write = 1'b0; cpu_cycle_end = 1'b0;

        #12;
        check("rst_pause", 32'(cpu_pause), 0);
        check("rst_granted", 32'(hs_granted), 0);
        check("rst_rdata", 32'(hs_rdata), 0);
        check("rst_we", 32'(ram_we), 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        check("idle_after_reset", 32'(cpu_pause), 0);

        // IDLE: RAM follows the CPU combinationally, hiscore inputs ignored.
        for (int i = 0; i < 4; i++) begin
            cpu_address = vt[i].ca; cpu_wdata = vt[i].cd; cpu_write = vt[i].cw;
            hs_address  = vt[i].ha; hs_wdata  = vt[i].hd; hs_write  = vt[i].hw;
            if (vt[i].ewe) push_wr(vt[i].ea, vt[i].ed);
            #1;
            check($sformatf("vec%0d_addr", i), 32'(ram_address), 32'(vt[i].ea));
            check($sformatf("vec%0d_data", i), 32'(ram_wdata), 32'(vt[i].ed));
            check($sformatf("vec%0d_we", i), 32'(ram_we), 32'(vt[i].ewe));
            check($sformatf("vec%0d_pause", i), 32'(cpu_pause), 0);
            check($sformatf("vec%0d_granted", i), 32'(hs_granted), 0);
            cyc();
        end

        // Request, safe pulse three cycles later, two settle cycles, grant.
        cpu_write = 1'b0; hs_write = 1'b0; cpu_address = 10'h040; hs_address = 10'h155;
        hs_access = 1'b1;
        #1;
        check("req_same_cycle_pause", 32'(cpu_pause), 0);
        cyc();
        check("req_pause_1cyc", 32'(cpu_pause), 1);
        check("wait_mux_cpu", 32'(ram_address), 32'h040);
        cyc();
        cyc();
        cpu_cycle_end = 1'b1;
        #1;
        check("pulse_cycle_granted", 32'(hs_granted), 0);
        cyc();
        cpu_cycle_end = 1'b0; hs_write = 1'b1; cpu_write = 1'b1;
        #1;
        check("settle1_we", 32'(ram_we), 0);
        check("settle1_mux_hs", 32'(ram_address), 32'h155);
        check("settle1_granted", 32'(hs_granted), 0);
        cyc();
        #1;
        check("settle2_we", 32'(ram_we), 0);
        check("settle2_granted", 32'(hs_granted), 0);
        cyc();
        hs_write = 1'b0; cpu_write = 1'b0;
        #1;
        check("grant_2_after_pulse", 32'(hs_granted), 1);
        check("owned_pause", 32'(cpu_pause), 1);

        // Owned write; simultaneous CPU write must be dropped.
        cyc();
        hs_address = 10'h123; hs_wdata = 8'hA5; hs_write = 1'b1;
        cpu_address = 10'h040; cpu_wdata = 8'h77; cpu_write = 1'b1;
        push_wr(10'h123, 8'hA5);
        #1;
        check("owned_we", 32'(ram_we), 1);
        check("owned_addr", 32'(ram_address), 32'h123);
        check("owned_data", 32'(ram_wdata), 32'hA5);
        cyc();
        hs_write = 1'b0; cpu_write = 1'b0;
        #1;
        check("owned_we_off", 32'(ram_we), 0);

        // Owned read: data two cycles after the address, held once back in IDLE.
        cyc();
        hs_address = 10'h010;
        cyc();
        check("rd_not_early", 32'(hs_rdata), 32'hA5);
        cyc();
        check("rd_2cyc", 32'(hs_rdata), 32'h5C);
        hs_access = 1'b0; hs_write = 1'b1; hs_wdata = 8'hEE;
        #1;
        check("drop_cycle_we", 32'(ram_we), 0);
        check("drop_cycle_granted", 32'(hs_granted), 1);
        cyc();
        hs_write = 1'b0; hs_access = 1'b1;
        #1;
        check("release_pause", 32'(cpu_pause), 1);
        check("release_granted", 32'(hs_granted), 0);
        check("release_we", 32'(ram_we), 0);
        check("release_mux_hs", 32'(ram_address), 32'h010);
        cyc();
        hs_access = 1'b0; cpu_address = 10'h020;
        #1;
        check("idle_after_release", 32'(cpu_pause), 0);
        check("idle_mux_cpu", 32'(ram_address), 32'h020);
        check("rdata_held_0", 32'(hs_rdata), 32'h5C);
        cyc();
        check("rerequest_ignored", 32'(cpu_pause), 0);
        check("rdata_held_1", 32'(hs_rdata), 32'h5C);
        cyc();
        check("rdata_held_2", 32'(hs_rdata), 32'h5C);

        // Request dropped in the same cycle as the safe pulse.
        hs_access = 1'b1; cpu_address = 10'h040;
        cyc();
        cyc();
        hs_access = 1'b0; cpu_cycle_end = 1'b1;
        #1;
        check("abort_cycle_pause", 32'(cpu_pause), 1);
        cyc();
        cpu_cycle_end = 1'b0;
        #1;
        check("abort_pause_low", 32'(cpu_pause), 0);
        check("abort_granted", 32'(hs_granted), 0);
        check("abort_mux_cpu", 32'(ram_address), 32'h040);
        cyc();
        cyc();
        check("abort_stays_idle", 32'(cpu_pause), 0);
        check("abort_no_grant", 32'(hs_granted), 0);

        // No safe pulse: timeout forces SETTLE 256 cycles after WAIT_SAFE entry.
        hs_access = 1'b1; hs_address = 10'h010; cpu_address = 10'h040;
        cyc();
        n = 0;
        while (ram_address !== 10'h010 && n < 400) begin
            n++;
            cyc();
        end
        check("timeout_wait_cycles", 32'(n), 256);
        check("timeout_settle1_granted", 32'(hs_granted), 0);
        cyc();
        check("timeout_settle2_granted", 32'(hs_granted), 0);
        cyc();
        check("timeout_grant", 32'(hs_granted), 1);

        // Reset while owned with a hiscore write in flight.
        cyc();
        hs_address = 10'h200; hs_wdata = 8'h11; hs_write = 1'b1;
        push_wr(10'h200, 8'h11);
        #1;
        check("pre_reset_we", 32'(ram_we), 1);
        cyc();
        check("pre_reset_rdata", 32'(hs_rdata), 32'h5C);
        cpu_address = 10'h0AB; cpu_wdata = 8'h3C; cpu_write = 1'b1;
        push_wr(10'h0AB, 8'h3C);
        reset_n = 1'b0;
        #1;
        check("rst_we_follows_cpu", 32'(ram_we), 1);
        check("rst_mux_addr", 32'(ram_address), 32'h0AB);
        check("rst_mux_data", 32'(ram_wdata), 32'h3C);
        check("rst_owned_pause", 32'(cpu_pause), 0);
        check("rst_owned_granted", 32'(hs_granted), 0);
        check("rst_owned_rdata", 32'(hs_rdata), 0);
        cyc();
        cpu_write = 1'b0; hs_write = 1'b0; hs_access = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        check("post_reset_idle", 32'(cpu_pause), 0);

        // Fresh request must go through WAIT_SAFE again.
        hs_access = 1'b1; hs_address = 10'h010; cpu_address = 10'h040;
        cyc();
        check("fresh_pause", 32'(cpu_pause), 1);
        check("fresh_wait_mux", 32'(ram_address), 32'h040);
        check("fresh_not_granted", 32'(hs_granted), 0);
        cyc();
        check("fresh_still_wait", 32'(ram_address), 32'h040);
        cpu_cycle_end = 1'b1;
        cyc();
        cpu_cycle_end = 1'b0;
        #1;
        check("fresh_settle_mux", 32'(ram_address), 32'h010);
        cyc();
        cyc();
        check("fresh_grant", 32'(hs_granted), 1);
        hs_access = 1'b0;
        cyc();
        cyc();
        check("fresh_back_idle", 32'(cpu_pause), 0);

        check("mem_123", 32'(rd(10'h123)), 32'hA5);
        check("mem_040_untouched", 32'(rd(10'h040)), 32'h00);
        check("mem_010_untouched", 32'(rd(10'h010)), 32'h5C);
        check("write_queue_empty", 32'(wq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
